// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and hands each
// fetched instruction to decode; taken branches redirect to branch_pc + ImmExt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] ImmExt,
  output logic        misalign_fault,
  output logic [31:0] fault_addr
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        kill_q, kill_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [31:0] target;
  logic        redir_req;
  logic        redirect;

  assign target    = branch_pc + ImmExt;
  assign redir_req = branch_taken && (state_q != StIdle);
  // Misaligned targets are reported but otherwise leave the fetch stream untouched.
  assign redirect  = redir_req && (target[1:0] == 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    kill_d        = kill_q;
    fault_d       = redir_req && (target[1:0] != 2'b00);
    fault_addr_d  = fault_d ? target : fault_addr_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redirect) begin
          pc_d = target;
          // The accepted address is already stale, so its response must be dropped.
          if (imem_req_ready) begin
            state_d = StWait;
            kill_d  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          pc_d = target;
          if (imem_rsp_valid) begin
            state_d = StReq;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill_q) begin
            state_d = StReq;
            kill_d  = 1'b0;
          end else begin
            instr_d       = imem_rsp_data;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + 32'd4;
            instr_valid_d = 1'b1;
            state_d       = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d          = target;
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= Nop;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      kill_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_addr_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      kill_q        <= kill_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign imem_req_valid = (state_q == StReq) && !reset;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign misalign_fault = fault_q;
  assign fault_addr     = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus queues expected requests, instructions
// and faults; a monitor pops and compares them whenever the DUT shows a handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] ImmExt;

  logic        imem_req_valid, instr_valid, misalign_fault;
  logic [31:0] imem_addr, instr, instr_pc, fault_addr;
  logic        w_imem_req_valid, w_instr_valid, w_misalign_fault;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc, w_fault_addr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .ImmExt(ImmExt),
    .misalign_fault(misalign_fault), .fault_addr(fault_addr)
  );

  // Lock-stepped twin with a wrapping reset PC; shares every input with dut.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .ImmExt(ImmExt),
    .misalign_fault(w_misalign_fault), .fault_addr(w_fault_addr)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_waddr[$];
  logic [31:0] exp_fault[$];
  logic [63:0] exp_instr[$];
  bit          mem_hold = 1'b0;
  bit          wrap_track = 1'b0;
  bit          seq_chk = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] paddr;
  time         last_t;
  int          n_seq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_addr.size() != 0 || exp_instr.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_addr.size() != 0 || exp_instr.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d req and %0d instr pending want 0",
               exp_addr.size(), exp_instr.size());
      exp_addr.delete();
      exp_instr.delete();
    end
  endtask

  task automatic push_instr(input logic [31:0] data, input logic [31:0] pc);
    exp_instr.push_back({data, pc});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_misalign"}, {31'b0, misalign_fault}, 32'd0);
    check({tag, "_fault_addr"}, fault_addr, 32'h0);
  endtask

  // Zero-wait memory: answers addr+0x100 one cycle after accept unless held.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        pend  = 1'b1;
        paddr = imem_addr;
      end
      @(posedge clk);
      #1;
      if (pend && !mem_hold) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = paddr + 32'h100;
        pend           = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got addr %h want no request", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_addr.pop_front());
        end
        if (wrap_track && exp_waddr.size() != 0) check("wrap_req_addr", w_imem_addr,
                                                       exp_waddr.pop_front());
      end
      if (instr_valid && instr_ready) begin
        if (exp_instr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL instr_unexpected: got %h at pc %h want none", instr, instr_pc);
        end else begin
          logic [63:0] e;
          e = exp_instr.pop_front();
          check("instr", instr, e[63:32]);
          check("instr_pc", instr_pc, e[31:0]);
        end
        if (seq_chk) begin
          if (n_seq > 0) check("instr_spacing", 32'($time - last_t), 32'd30);
          last_t = $time;
          n_seq++;
        end
      end
      if (misalign_fault) begin
        if (exp_fault.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fault_unexpected: got fault_addr %h want no fault", fault_addr);
        end else begin
          check("fault_addr", fault_addr, exp_fault.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    branch_taken   = 1'b0;
    branch_pc      = 32'h0;
    ImmExt         = 32'h0;
    tick(2);
    check_reset_vals("rst");
    check("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
    check("wrap_rst_instr_pc", w_instr_pc, 32'hFFFF_FFFC);

    // Sequential fetch at 3-cycle spacing; the twin wraps to 0x0 on its second request.
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    push_instr(32'h100, 32'h0); push_instr(32'h104, 32'h4); push_instr(32'h108, 32'h8);
    exp_waddr.push_back(32'hFFFF_FFFC); exp_waddr.push_back(32'h0);
    exp_waddr.push_back(32'h4);
    wrap_track = 1'b1;
    seq_chk    = 1'b1;
    reset      = 1'b0;
    check("startup_idle", {31'b0, imem_req_valid}, 32'd0);
    tick(1);
    check("startup_req", {31'b0, imem_req_valid}, 32'd1);
    wait_drain(40);
    wrap_track = 1'b0;
    seq_chk    = 1'b0;

    // Request backpressure: address must hold steady while not accepted.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", {31'b0, imem_req_valid}, 32'd1);
      check("bp_addr", imem_addr, 32'hC);
      tick(1);
    end
    exp_addr.push_back(32'hC);
    push_instr(32'h10C, 32'hC);
    imem_req_ready = 1'b1;
    wait_drain(20);

    // Backward redirect in WAIT, same cycle as the response: response dropped.
    exp_addr.push_back(32'h10);
    tick(1);
    branch_taken = 1'b1;
    branch_pc    = 32'h10;
    ImmExt       = 32'hFFFF_FFF8;
    exp_addr.push_back(32'h8);
    push_instr(32'h108, 32'h8);
    tick(1);
    branch_taken = 1'b0;
    check("wait_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    check("wait_redir_addr", imem_addr, 32'h8);
    wait_drain(20);

    // Redirect in HOLD while decode is ready: redirect wins.
    exp_addr.push_back(32'hC);
    push_instr(32'h10C, 32'hC);
    tick(2);
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    branch_taken = 1'b1;
    branch_pc    = 32'h20;
    ImmExt       = 32'h40;
    exp_addr.push_back(32'h60);
    push_instr(32'h160, 32'h60);
    tick(1);
    branch_taken = 1'b0;
    check("hold_flush", {31'b0, instr_valid}, 32'd0);
    check("hold_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    check("hold_redir_addr", imem_addr, 32'h60);
    wait_drain(20);

    // Misaligned target: one-cycle fault, stream continues sequentially.
    exp_addr.push_back(32'h64); exp_addr.push_back(32'h68);
    push_instr(32'h164, 32'h64); push_instr(32'h168, 32'h68);
    exp_fault.push_back(32'hA);
    branch_taken = 1'b1;
    branch_pc    = 32'h8;
    ImmExt       = 32'h2;
    tick(1);
    branch_taken = 1'b0;
    check("misalign_hi", {31'b0, misalign_fault}, 32'd1);
    check("misalign_addr", fault_addr, 32'hA);
    tick(1);
    check("misalign_lo", {31'b0, misalign_fault}, 32'd0);
    check("misalign_addr_held", fault_addr, 32'hA);
    wait_drain(20);

    // Reset while WAIT with the response held back; the late response must be ignored.
    mem_hold = 1'b1;
    exp_addr.push_back(32'h6C);
    tick(2);
    reset = 1'b1;
    tick(2);
    check_reset_vals("mid_rst");
    imem_req_ready = 1'b0;
    reset          = 1'b0;
    mem_hold       = 1'b0;
    check("rerst_idle", {31'b0, imem_req_valid}, 32'd0);
    tick(1);
    check("rerst_req", {31'b0, imem_req_valid}, 32'd1);
    check("rerst_addr", imem_addr, 32'h0);
    tick(3);
    check("stale_rsp_ignored", {31'b0, instr_valid}, 32'd0);
    check("stale_rsp_instr", instr, 32'h0000_0013);
    exp_addr.push_back(32'h0);
    push_instr(32'h100, 32'h0);
    imem_req_ready = 1'b1;
    wait_drain(20);

    check("left_req", 32'(exp_addr.size()), 32'd0);
    check("left_instr", 32'(exp_instr.size()), 32'd0);
    check("left_fault", 32'(exp_fault.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
